// File: rtl/cmd_frame_decode_pkg.sv
// cmd_frame_decode_pkg
//   Shared definitions for the framed UART command decoder: FSM state
//   encodings, default opcodes and err_code values.
package cmd_frame_decode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DATA  = 3'd4,
    ST_ISSUE = 3'd5
  } frame_state_e;

  localparam logic [7:0] OP_WR_DEF = 8'h55;
  localparam logic [7:0] OP_RD_DEF = 8'hAA;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_LEN      = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_CSUM     = 3'd5;

endpackage

// File: rtl/cmd_frame_decode_timeout.sv
// frame_timeout_cnt
//   Inter-byte timeout counter shared by the UART framing blocks.
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_clr          : restart the interval (a byte arrived)
//     i_en           : count while high; held at zero while low
//     o_expire       : 1-cycle pulse on the TIMEOUT_CYC-th counted cycle
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1_400_000,
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CW-1:0] r_cnt;

  // Clearing while disabled means every frame starts from a fresh interval.
  // Saturates at TIMEOUT_CYC so a stuck enable can never wrap and re-fire.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_cnt <= '0;
    else if (i_clr || !i_en)            r_cnt <= '0;
    else if (r_cnt != CW'(TIMEOUT_CYC)) r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the cycle that would take the count to TIMEOUT_CYC, so the
  // owner can act in the same cycle; a byte in that cycle wins.
  assign o_expire = i_en & ~i_clr & (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmd_frame_decode.sv
// cmd_frame_decode
//   Parses framed commands from uart_rx:
//     opcode, ADDR_BYTES address bytes (MSB first), length, [checksum], payload
//   Write payload is pushed to the write FIFO; once the frame completes an
//   addressed wr/rd trigger is issued to sdram_top when it is idle.
//   Optional feature: define CMD_CSUM_EN to require a checksum byte (XOR of
//   opcode, address and length bytes) after the length byte.
//   Ports:
//     sys_clk, sys_rst_n     : clock, async active-low reset
//     uart_flag, uart_data   : received byte strobe and byte
//     sdram_busy             : controller busy, holds off the trigger
//     wfifo_full             : write FIFO full, a payload byte is dropped
//     wfifo_wr_en, wfifo_data: FIFO push, one cycle after the byte
//     wr_trig, rd_trig       : 1-cycle command triggers
//     cmd_addr, cmd_len      : issued command, held after the trigger
//     err, err_code          : 1-cycle error pulse, code held until next err
module cmd_frame_decode
  import cmd_frame_decode_pkg::*;
#(
  parameter int D_WIDTH     = 8,
  parameter int ADDR_BYTES  = 3,
  parameter int MAX_BURST   = 16,
  parameter int LEN_W       = 5,
  parameter int TIMEOUT_CYC = 1_400_000,
  parameter logic [D_WIDTH-1:0] OP_WR = D_WIDTH'(OP_WR_DEF),
  parameter logic [D_WIDTH-1:0] OP_RD = D_WIDTH'(OP_RD_DEF),
  localparam int AW = ADDR_BYTES * D_WIDTH
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               uart_flag,
  input  logic [D_WIDTH-1:0] uart_data,
  input  logic               sdram_busy,
  input  logic               wfifo_full,
  output logic               wfifo_wr_en,
  output logic [D_WIDTH-1:0] wfifo_data,
  output logic               wr_trig,
  output logic               rd_trig,
  output logic [AW-1:0]      cmd_addr,
  output logic [LEN_W-1:0]   cmd_len,
  output logic               err,
  output logic [2:0]         err_code
);

`ifdef CMD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int ACNT_W = $clog2(ADDR_BYTES + 1);
  localparam logic [D_WIDTH-1:0] MAXB = D_WIDTH'(MAX_BURST);

  frame_state_e       r_state;
  logic               r_is_wr;
  logic [AW-1:0]      r_addr_sr;
  logic [LEN_W-1:0]   r_len;
  logic [ACNT_W-1:0]  r_acnt;
  logic [LEN_W-1:0]   r_bcnt;
  logic [D_WIDTH-1:0] r_csum;
  logic               w_to_en;
  logic               w_expire;

  assign w_to_en = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                   (r_state == ST_CSUM) || (r_state == ST_DATA);

  frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_clr    (uart_flag),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_is_wr     <= 1'b0;
      r_addr_sr   <= '0;
      r_len       <= '0;
      r_acnt      <= '0;
      r_bcnt      <= '0;
      r_csum      <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      wfifo_wr_en <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (uart_flag) begin
            if (uart_data == OP_WR || uart_data == OP_RD) begin
              r_is_wr   <= (uart_data == OP_WR);
              r_csum    <= uart_data;
              r_addr_sr <= '0;
              r_acnt    <= '0;
              r_state   <= ST_ADDR;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_OPCODE;
            end
          end
        end

        ST_ADDR: begin
          if (w_expire) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            r_state  <= ST_IDLE;
          end else if (uart_flag) begin
            r_addr_sr <= (r_addr_sr << D_WIDTH) | AW'(uart_data);
            r_csum    <= r_csum ^ uart_data;
            if (r_acnt == ACNT_W'(ADDR_BYTES - 1)) r_state <= ST_LEN;
            else                                   r_acnt  <= r_acnt + 1'b1;
          end
        end

        ST_LEN: begin
          if (w_expire) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            r_state  <= ST_IDLE;
          end else if (uart_flag) begin
            // Range check on the full byte so out-of-range values cannot
            // alias into a legal LEN_W-bit length.
            if (uart_data == '0 || uart_data > MAXB) begin
              err      <= 1'b1;
              err_code <= ERR_LEN;
              r_state  <= ST_IDLE;
            end else begin
              r_len  <= LEN_W'(uart_data);
              r_csum <= r_csum ^ uart_data;
              r_bcnt <= '0;
              if (CSUM_EN)      r_state <= ST_CSUM;
              else if (r_is_wr) r_state <= ST_DATA;
              else              r_state <= ST_ISSUE;
            end
          end
        end

        ST_CSUM: begin
          if (w_expire) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            r_state  <= ST_IDLE;
          end else if (uart_flag) begin
            if (uart_data != r_csum) begin
              err      <= 1'b1;
              err_code <= ERR_CSUM;
              r_state  <= ST_IDLE;
            end else if (r_is_wr) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end

        ST_DATA: begin
          if (w_expire) begin
            // Bytes already pushed stay in the FIFO; the consumer never
            // sees a trigger for them.
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            r_state  <= ST_IDLE;
          end else if (uart_flag) begin
            if (wfifo_full) begin
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
              r_state  <= ST_IDLE;
            end else begin
              wfifo_wr_en <= 1'b1;
              wfifo_data  <= uart_data;
              if (r_bcnt == r_len - LEN_W'(1)) r_state <= ST_ISSUE;
              else                             r_bcnt  <= r_bcnt + 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          // A stray byte takes the err pulse this cycle and pushes the
          // trigger out by one, so err and a trigger never share a cycle.
          if (uart_flag) begin
            err      <= 1'b1;
            err_code <= ERR_OVERFLOW;
          end else if (!sdram_busy) begin
            wr_trig  <= r_is_wr;
            rd_trig  <= ~r_is_wr;
            cmd_addr <= r_addr_sr;
            cmd_len  <= r_len;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
